rom_ctrl_check_seq: RTL and testbench
=====================================

Name: rom_ctrl_check_seq

Overview:
- Sequencer for the ROM integrity check.
- After the hash engine finishes, it fetches the expected digest words from the top of ROM and captures the computed digest.
- It then starts the digest comparator, waits for its verdict, and publishes done/good to the power manager and key manager.
- It sits between the ROM read port, the KMAC digest return and the comparator. It owns the DIGEST/EXP_DIGEST register contents.

Parameters:
- NumWords, 8, number of 32-bit digest words (>=1).
- RomAw, 12, ROM word-address width.
- ExpBase, 12'hFF8, ROM word address of expected-digest word 0. Word i is at ExpBase+i. ExpBase+NumWords-1 must fit in RomAw bits.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async reset, active-low
- init_i  in  1  start pulse: ROM hashing has finished
- exp_req_o  out  1  one-cycle ROM read request
- exp_addr_o  out  RomAw  ROM read address
- exp_rvalid_i  in  1  ROM read data valid
- exp_rdata_i  in  32  ROM read data
- kmac_valid_i  in  1  computed-digest valid (single-cycle pulse)
- kmac_digest_i  in  NumWords*32  computed digest, word 0 in LSBs
- digest_o  out  NumWords*32  captured computed digest
- exp_digest_o  out  NumWords*32  captured expected digest
- cmp_start_o  out  1  comparator start pulse
- cmp_done_i  in  1  comparator done (level)
- cmp_good_i  in  4  comparator verdict, mubi4
- done_o  out  1  check complete, to power manager
- good_o  out  4  final verdict, mubi4
- alert_o  out  1  fatal consistency alert (level, sticky)

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i.
- Reset values:
  - state Idle; word index 0.
  - digest_o and exp_digest_o all-zero; kmac_seen 0; outstanding 0.
  - exp_req_o, cmp_start_o, done_o, alert_o all 0.
  - good_o MuBi4False.
- FSM is sparse-encoded with states Idle, ReadExp, WaitKmac, Compare, Done, Error. Any invalid encoding goes to Error.
- Idle:
  - init_i -> ReadExp in the next cycle.
  - kmac_valid_i in Idle is ignored; the digest is not captured.
- ReadExp:
  - With no read outstanding and idx<NumWords: assert exp_req_o for exactly one cycle with exp_addr_o=ExpBase+idx, then set outstanding.
  - At most one read is outstanding. exp_req_o and exp_rvalid_i may coincide only if the response belongs to the previous request; the next request comes at the earliest the cycle after rvalid.
  - exp_rvalid_i with outstanding set: write exp_rdata_i into exp_digest_o word idx, clear outstanding, idx++.
  - When the last word (idx=NumWords-1) returns: go to Compare if kmac_seen, else to WaitKmac.
- kmac_valid_i in ReadExp or WaitKmac (first pulse only):
  - Capture kmac_digest_i into digest_o and set kmac_seen.
  - In WaitKmac, move to Compare in the next cycle.
  - A second kmac_valid_i after kmac_seen -> Error.
  - If kmac_valid_i and the final rvalid arrive in the same cycle, both are captured and the FSM goes directly to Compare.
- Compare:
  - cmp_start_o pulses for exactly one cycle, in the first cycle of Compare.
  - Then wait for cmp_done_i; when it is seen, latch good_o=cmp_good_i and go to Done. Latency from cmp_start_o to the latch is the comparator latency +1 cycle.
  - cmp_good_i that is not a valid mubi4 value is latched as MuBi4False.
- Done:
  - Terminal state. done_o=1 and good_o held until reset.
  - digest_o and exp_digest_o are frozen from Compare onward.
- Error:
  - Terminal state. alert_o=1, done_o=0, good_o=MuBi4False.
  - exp_req_o and cmp_start_o are held at 0.
- Alert (Error-entry) conditions, all sticky:
  - init_i outside Idle.
  - exp_rvalid_i with no read outstanding.
  - A second kmac_valid_i.
  - cmp_done_i outside Compare.
  - Invalid FSM encoding.
  - Word index that is not 0 in Idle.
- Reset mid-operation: everything returns to reset values immediately and asynchronously; an in-flight ROM response after reset is ignored only if it arrives before init_i. If it arrives in Idle it is harmless, since rvalid is only checked outside Idle.
- Arithmetic:
  - idx is vbits(NumWords)+1 bits wide and never wraps; it saturates at NumWords.
  - Address computation is RomAw wide with no carry-out.

Test Plan:
1. Nominal check, NumWords=8, ROM latency 1:
   - Stimulus: init_i; 8 reads return 32'h1000_000i; kmac_valid_i arrives during word 3 with matching digest; comparator answers cmp_done_i with MuBi4True after 8 cycles.
   - Required: exp_addr_o sequence 0xFF8..0xFFF; exactly one cmp_start_o pulse; done_o=1; good_o=MuBi4True.
2. KMAC late:
   - Stimulus: all 8 words read, FSM enters WaitKmac, kmac_valid_i arrives 20 cycles later.
   - Required: cmp_start_o exactly 1 cycle after kmac_valid_i.
3. Simultaneous events:
   - Stimulus: final exp_rvalid_i and kmac_valid_i in the same cycle.
   - Required: both captured, cmp_start_o in the next cycle, no alert.
4. Mismatch and invalid verdict:
   - Stimulus: cmp_good_i=MuBi4False -> good_o=MuBi4False with done_o=1; then repeat with cmp_good_i=4'b0000.
   - Required: good_o=MuBi4False in both runs.
5. Protocol violations, one per run:
   - Stimulus: spurious exp_rvalid_i; init_i during ReadExp; double kmac_valid_i; cmp_done_i in Idle.
   - Required: alert_o=1 from the next cycle onward, done_o stays 0.
6. Reset mid-ReadExp:
   - Stimulus: assert rst_ni low after 4 words, then rerun the nominal test.
   - Required: all outputs at reset values during reset; second run passes with addresses restarting at 0xFF8.

Source files
------------

// File: rtl/rom_ctrl_check_seq.sv
// ROM integrity check sequencer.
// Fetches the expected digest from the top of ROM, captures the KMAC digest,
// runs the digest comparator and publishes the final done/good verdict.
// Any protocol inconsistency parks the block in a terminal Error state with a sticky alert.
module rom_ctrl_check_seq #(
    parameter int unsigned      NumWords = 8,
    parameter int unsigned      RomAw    = 12,
    parameter logic [RomAw-1:0] ExpBase  = 12'hFF8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   init_i,
    output logic                   exp_req_o,
    output logic [RomAw-1:0]       exp_addr_o,
    input  logic                   exp_rvalid_i,
    input  logic [31:0]            exp_rdata_i,
    input  logic                   kmac_valid_i,
    input  logic [NumWords*32-1:0] kmac_digest_i,
    output logic [NumWords*32-1:0] digest_o,
    output logic [NumWords*32-1:0] exp_digest_o,
    output logic                   cmp_start_o,
    input  logic                   cmp_done_i,
    input  logic [3:0]             cmp_good_i,
    output logic                   done_o,
    output logic [3:0]             good_o,
    output logic                   alert_o
);

    // One extra bit so the index can reach NumWords without wrapping.
    localparam int unsigned      IdxW    = ((NumWords > 1) ? $clog2(NumWords) : 1) + 1;
    localparam logic [IdxW-1:0]  NumIdx  = IdxW'(NumWords);
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumWords - 1);

    localparam logic [3:0] MuBi4True  = 4'h6;
    localparam logic [3:0] MuBi4False = 4'h9;

    // Sparse encoding: every pair of legal states differs in at least three bits.
    typedef enum logic [5:0] {
        StIdle     = 6'b100101,
        StReadExp  = 6'b011100,
        StWaitKmac = 6'b110010,
        StCompare  = 6'b001011,
        StDone     = 6'b111001,
        StError    = 6'b010111
    } state_e;

    // Anything other than an explicit MuBi4True is treated as a failing verdict.
    function automatic logic [3:0] sanitize_mubi4(input logic [3:0] v);
        return (v == MuBi4True) ? MuBi4True : MuBi4False;
    endfunction

    state_e                 r_state;
    logic [IdxW-1:0]        r_idx;
    logic                   r_outstanding;
    logic                   r_kmac_seen;
    logic                   r_req;
    logic [RomAw-1:0]       r_addr;
    logic                   r_cmp_start;
    logic                   r_done;
    logic                   r_alert;
    logic [3:0]             r_good;
    logic [NumWords*32-1:0] r_digest;
    logic [NumWords*32-1:0] r_exp_digest;

    logic            w_state_valid;
    logic            w_in_idle;
    logic            w_reading;
    logic            w_collecting;
    logic            w_rsp;
    logic            w_last_rsp;
    logic            w_kmac_cap;
    logic            w_kmac_seen_nxt;
    logic [IdxW-1:0] w_idx_nxt;
    logic            w_issue;
    logic            w_proto_err;

    assign w_state_valid = r_state inside {StIdle, StReadExp, StWaitKmac, StCompare, StDone, StError};
    assign w_in_idle     = (r_state == StIdle);
    assign w_reading     = (r_state == StReadExp);
    assign w_collecting  = w_reading || (r_state == StWaitKmac);

    // A ROM response is only meaningful against the single outstanding request.
    assign w_rsp      = w_reading && exp_rvalid_i && r_outstanding;
    assign w_last_rsp = w_rsp && (r_idx == LastIdx);

    // Only the first KMAC pulse of a check is captured; a second one is an error.
    assign w_kmac_cap      = w_collecting && kmac_valid_i && !r_kmac_seen;
    assign w_kmac_seen_nxt = r_kmac_seen || w_kmac_cap;

    // Index saturates at NumWords; the next request may issue on the response edge.
    assign w_idx_nxt = (w_rsp && (r_idx < NumIdx)) ? r_idx + IdxW'(1) : r_idx;
    assign w_issue   = w_reading && (!r_outstanding || w_rsp) && (w_idx_nxt < NumIdx);

    // A completion that stays high in Done is the normal level behaviour of the comparator.
    assign w_proto_err = (init_i && !w_in_idle)
                       || (exp_rvalid_i && !r_outstanding && !w_in_idle)
                       || (kmac_valid_i && r_kmac_seen)
                       || (cmp_done_i && (r_state != StCompare) && (r_state != StDone))
                       || (w_in_idle && (r_idx != '0));

    // Sequencer FSM with registered outputs and the captured digest registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_outstanding <= 1'b0;
            r_kmac_seen   <= 1'b0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_cmp_start   <= 1'b0;
            r_done        <= 1'b0;
            r_alert       <= 1'b0;
            r_good        <= MuBi4False;
            r_digest      <= '0;
            r_exp_digest  <= '0;
        end else begin
            r_req       <= 1'b0;
            r_cmp_start <= 1'b0;
            if (!w_state_valid || w_proto_err || (r_state == StError)) begin
                r_state       <= StError;
                r_alert       <= 1'b1;
                r_done        <= 1'b0;
                r_good        <= MuBi4False;
                r_outstanding <= 1'b0;
            end else begin
                if (w_kmac_cap) begin
                    r_digest    <= kmac_digest_i;
                    r_kmac_seen <= 1'b1;
                end
                case (r_state)
                    StIdle: begin
                        if (init_i) begin
                            r_state <= StReadExp;
                        end
                    end
                    StReadExp: begin
                        if (w_rsp) begin
                            for (int unsigned i = 0; i < NumWords; i++) begin
                                if (r_idx == IdxW'(i)) begin
                                    r_exp_digest[i*32 +: 32] <= exp_rdata_i;
                                end
                            end
                            r_idx <= w_idx_nxt;
                        end
                        if (w_issue) begin
                            r_req         <= 1'b1;
                            r_addr        <= ExpBase + RomAw'(w_idx_nxt);
                            r_outstanding <= 1'b1;
                        end else if (w_rsp) begin
                            r_outstanding <= 1'b0;
                        end
                        if (w_last_rsp) begin
                            if (w_kmac_seen_nxt) begin
                                r_state     <= StCompare;
                                r_cmp_start <= 1'b1;
                            end else begin
                                r_state <= StWaitKmac;
                            end
                        end
                    end
                    StWaitKmac: begin
                        if (w_kmac_cap) begin
                            r_state     <= StCompare;
                            r_cmp_start <= 1'b1;
                        end
                    end
                    StCompare: begin
                        if (cmp_done_i) begin
                            r_good  <= sanitize_mubi4(cmp_good_i);
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end
                    end
                    StDone: begin
                        r_state <= StDone;
                    end
                    default: begin
                        r_state <= StError;
                        r_alert <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign exp_req_o    = r_req;
    assign exp_addr_o   = r_addr;
    assign digest_o     = r_digest;
    assign exp_digest_o = r_exp_digest;
    assign cmp_start_o  = r_cmp_start;
    assign done_o       = r_done;
    assign good_o       = r_good;
    assign alert_o      = r_alert;

endmodule

// File: tb/tb_rom_ctrl_check_seq.sv
// Directed testbench for rom_ctrl_check_seq (NumWords=8, ROM latency 1).
`timescale 1ns/1ps
module tb_rom_ctrl_check_seq;

    localparam int NW = 8;

    logic            clk;
    logic            rst_n;
    logic            init;
    logic            exp_req;
    logic [11:0]     exp_addr;
    logic            rom_rvalid;
    logic            frc_rvalid;
    logic            exp_rvalid;
    logic [31:0]     rom_rdata;
    logic            kmac_valid;
    logic [NW*32-1:0] kmac_digest;
    logic [NW*32-1:0] digest;
    logic [NW*32-1:0] exp_digest;
    logic [NW*32-1:0] golden;
    logic            cmp_start;
    logic            cmp_done;
    logic [3:0]      cmp_good;
    logic            done;
    logic [3:0]      good;
    logic            alert;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0] addr_log [16];
    int n_addr, n_start, kmac_cyc, start_cyc, fin_cyc, last_rv;

    assign exp_rvalid = rom_rvalid | frc_rvalid;

    rom_ctrl_check_seq #(.NumWords(NW), .RomAw(12), .ExpBase(12'hFF8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .init_i       (init),
        .exp_req_o    (exp_req),
        .exp_addr_o   (exp_addr),
        .exp_rvalid_i (exp_rvalid),
        .exp_rdata_i  (rom_rdata),
        .kmac_valid_i (kmac_valid),
        .kmac_digest_i(kmac_digest),
        .digest_o     (digest),
        .exp_digest_o (exp_digest),
        .cmp_start_o  (cmp_start),
        .cmp_done_i   (cmp_done),
        .cmp_good_i   (cmp_good),
        .done_o       (done),
        .good_o       (good),
        .alert_o      (alert)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        init       = 1'b0;
        rom_rvalid = 1'b0;
        frc_rvalid = 1'b0;
        kmac_valid = 1'b0;
        cmp_done   = 1'b0;
        cmp_good   = 4'h9;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one full check: ROM with latency 1, KMAC pulse, comparator answering 8 cycles after start.
    // kmac_at>=0: pulse together with the response of word kmac_at; kmac_late>0: pulse that many cycles after the last response.
    task automatic run_seq(input int kmac_at, input int kmac_late, input logic [3:0] verdict, input int stop_words);
        int words;
        bit pend;
        logic [31:0] pdata;
        words = 0; pend = 1'b0; pdata = '0;
        n_addr = 0; n_start = 0; kmac_cyc = -1; start_cyc = -1; fin_cyc = -1; last_rv = -1;
        @(negedge clk);
        init = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            idle_inputs();
            if (done || alert) begin fin_cyc = cyc; break; end
            if (stop_words > 0 && words == stop_words) break;
            if (pend) begin
                rom_rvalid = 1'b1; rom_rdata = pdata; words++;
                if (words == NW) last_rv = cyc;
            end
            pend = exp_req;
            if (exp_req) begin
                if (n_addr < 16) addr_log[n_addr] = exp_addr;
                n_addr++;
                pdata = 32'h1000_0000 + 32'(exp_addr - 12'hFF8);
            end
            if (cmp_start) begin n_start++; if (start_cyc < 0) start_cyc = cyc; end
            if (kmac_cyc < 0 && ((kmac_at >= 0 && rom_rvalid && words == kmac_at + 1) ||
                                 (kmac_late > 0 && last_rv >= 0 && cyc == last_rv + kmac_late))) begin
                kmac_valid = 1'b1; kmac_cyc = cyc;
            end
            if (start_cyc >= 0 && cyc == start_cyc + 8) begin cmp_done = 1'b1; cmp_good = verdict; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        n_cmp++; if ({exp_req, cmp_start, done, alert, good} !== 8'h09) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 09", {exp_req, cmp_start, done, alert, good}); end
        n_cmp++; if (digest !== '0) begin n_fail++; $display("FAIL reset_digest: got %h expected 0", digest); end
        n_cmp++; if (exp_digest !== '0) begin n_fail++; $display("FAIL reset_exp_digest: got %h expected 0", exp_digest); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_kmac();
        @(negedge clk);
        kmac_valid = 1'b1;
        @(negedge clk);
        kmac_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (digest !== '0) begin n_fail++; $display("FAIL idle_kmac_digest: got %h expected 0", digest); end
        n_cmp++; if (alert !== 1'b0) begin n_fail++; $display("FAIL idle_kmac_alert: got %b expected 0", alert); end
    endtask

    task automatic test_nominal();
        logic [11:0] ea;
        apply_reset();
        run_seq(3, 0, 4'h6, 0);
        n_cmp++; if (n_addr !== NW) begin n_fail++; $display("FAIL nom_req_count: got %0d expected %0d", n_addr, NW); end
        for (int i = 0; i < NW; i++) begin
            ea = 12'hFF8 + 12'(i);
            n_cmp++; if (addr_log[i] !== ea) begin n_fail++; $display("FAIL nom_addr%0d: got %h expected %h", i, addr_log[i], ea); end
        end
        n_cmp++; if (n_start !== 1) begin n_fail++; $display("FAIL nom_start_count: got %0d expected 1", n_start); end
        n_cmp++; if (start_cyc !== last_rv + 1) begin n_fail++; $display("FAIL nom_start_cycle: got %0d expected %0d", start_cyc, last_rv + 1); end
        n_cmp++; if (fin_cyc !== start_cyc + 9) begin n_fail++; $display("FAIL nom_done_latency: got %0d expected %0d", fin_cyc, start_cyc + 9); end
        n_cmp++; if ({done, good, alert} !== 6'b1_0110_0) begin n_fail++; $display("FAIL nom_verdict: got done/good/alert %b expected 1_0110_0", {done, good, alert}); end
        n_cmp++; if (digest !== golden) begin n_fail++; $display("FAIL nom_digest: got %h expected %h", digest, golden); end
        n_cmp++; if (exp_digest !== golden) begin n_fail++; $display("FAIL nom_exp_digest: got %h expected %h", exp_digest, golden); end
        repeat (4) @(negedge clk);
        n_cmp++; if ({done, good, alert, exp_req, cmp_start} !== 8'b1_0110_000) begin n_fail++; $display("FAIL nom_done_hold: got %b expected 10110000", {done, good, alert, exp_req, cmp_start}); end
    endtask

    task automatic test_kmac_late();
        apply_reset();
        run_seq(-1, 20, 4'h6, 0);
        n_cmp++; if (start_cyc !== kmac_cyc + 1) begin n_fail++; $display("FAIL late_start_cycle: got %0d expected %0d", start_cyc, kmac_cyc + 1); end
        n_cmp++; if (n_start !== 1) begin n_fail++; $display("FAIL late_start_count: got %0d expected 1", n_start); end
        n_cmp++; if ({done, good, alert} !== 6'b1_0110_0) begin n_fail++; $display("FAIL late_verdict: got %b expected 101100", {done, good, alert}); end
        n_cmp++; if (digest !== golden) begin n_fail++; $display("FAIL late_digest: got %h expected %h", digest, golden); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        run_seq(7, 0, 4'h6, 0);
        n_cmp++; if (start_cyc !== kmac_cyc + 1) begin n_fail++; $display("FAIL simul_start_cycle: got %0d expected %0d", start_cyc, kmac_cyc + 1); end
        n_cmp++; if (alert !== 1'b0) begin n_fail++; $display("FAIL simul_alert: got %b expected 0", alert); end
        n_cmp++; if (digest !== golden) begin n_fail++; $display("FAIL simul_digest: got %h expected %h", digest, golden); end
        n_cmp++; if (exp_digest !== golden) begin n_fail++; $display("FAIL simul_exp_digest: got %h expected %h", exp_digest, golden); end
        n_cmp++; if ({done, good} !== 5'b1_0110) begin n_fail++; $display("FAIL simul_verdict: got %b expected 10110", {done, good}); end
    endtask

    task automatic test_mismatch();
        apply_reset();
        run_seq(3, 0, 4'h9, 0);
        n_cmp++; if ({done, good, alert} !== 6'b1_1001_0) begin n_fail++; $display("FAIL mism_false: got %b expected 110010", {done, good, alert}); end
        apply_reset();
        run_seq(3, 0, 4'h0, 0);
        n_cmp++; if ({done, good, alert} !== 6'b1_1001_0) begin n_fail++; $display("FAIL mism_invalid: got %b expected 110010", {done, good, alert}); end
    endtask

    // kind 0: spurious rvalid, 1: init in ReadExp, 2: double kmac, 3: cmp_done in Idle
    task automatic test_violation(input int kind);
        apply_reset();
        @(negedge clk);
        if (kind != 3) begin
            init = 1'b1;
            @(negedge clk);
            init = 1'b0;
        end
        if (kind == 2) begin
            kmac_valid = 1'b1;
            @(negedge clk);
            kmac_valid = 1'b0;
        end
        n_cmp++; if (alert !== 1'b0) begin n_fail++; $display("FAIL viol%0d_pre_alert: got %b expected 0", kind, alert); end
        case (kind)
            0: frc_rvalid = 1'b1;
            1: init = 1'b1;
            2: kmac_valid = 1'b1;
            default: cmp_done = 1'b1;
        endcase
        @(negedge clk);
        idle_inputs();
        n_cmp++; if ({alert, done} !== 2'b10) begin n_fail++; $display("FAIL viol%0d_alert: got alert/done %b expected 10", kind, {alert, done}); end
        repeat (4) @(negedge clk);
        n_cmp++; if ({alert, done, exp_req, cmp_start, good} !== 8'b1000_1001) begin n_fail++; $display("FAIL viol%0d_sticky: got %b expected 10001001", kind, {alert, done, exp_req, cmp_start, good}); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] ea;
        apply_reset();
        run_seq(3, 0, 4'h6, 4);
        n_cmp++; if (digest !== golden) begin n_fail++; $display("FAIL mid_pre_digest: got %h expected %h", digest, golden); end
        rst_n = 1'b0;
        idle_inputs();
        #1;
        n_cmp++; if ({exp_req, cmp_start, done, alert, good} !== 8'h09) begin n_fail++; $display("FAIL mid_reset_ctrl: got %h expected 09", {exp_req, cmp_start, done, alert, good}); end
        n_cmp++; if (digest !== '0) begin n_fail++; $display("FAIL mid_reset_digest: got %h expected 0", digest); end
        n_cmp++; if (exp_digest !== '0) begin n_fail++; $display("FAIL mid_reset_exp_digest: got %h expected 0", exp_digest); end
        @(negedge clk);
        rst_n = 1'b1;
        rom_rvalid = 1'b1;
        rom_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        rom_rvalid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({alert, exp_digest[31:0]} !== 33'h0) begin n_fail++; $display("FAIL mid_stale_rsp: got %h expected 0", {alert, exp_digest[31:0]}); end
        run_seq(3, 0, 4'h6, 0);
        for (int i = 0; i < NW; i++) begin
            ea = 12'hFF8 + 12'(i);
            n_cmp++; if (addr_log[i] !== ea) begin n_fail++; $display("FAIL mid_rerun_addr%0d: got %h expected %h", i, addr_log[i], ea); end
        end
        n_cmp++; if ({done, good, alert} !== 6'b1_0110_0) begin n_fail++; $display("FAIL mid_rerun_verdict: got %b expected 101100", {done, good, alert}); end
        n_cmp++; if (exp_digest !== golden) begin n_fail++; $display("FAIL mid_rerun_exp_digest: got %h expected %h", exp_digest, golden); end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) golden[i*32 +: 32] = 32'h1000_0000 + 32'(i);
        kmac_digest = golden;
        rom_rdata   = '0;
        test_reset();
        test_idle_kmac();
        test_nominal();
        test_kmac_late();
        test_simultaneous();
        test_mismatch();
        for (int k = 0; k < 4; k++) test_violation(k);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
